calc_datapath_p: RTL and testbench

CALC_DATAPATH_P -- requirements
Module: calc_datapath_p

---
 rtl/calc_pkg.sv | 27 ++
 rtl/calc_rf.sv | 33 +++
 rtl/calc_datapath_p.sv | 189 ++++++++++++++++++
 tb/tb_calc_datapath_p.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types for the register-file calculator: op codes, FSM states and op helpers.
package calc_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_LOAD1 = 3'b000,
        OP_LOAD2 = 3'b001,
        OP_CLR   = 3'b010,
        OP_ADD   = 3'b011,
        OP_SUB   = 3'b100,
        OP_AND   = 3'b101,
        OP_XOR   = 3'b110,
        OP_MUL   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2
    } state_e;

    function automatic logic is_multicycle(input op_e op);
        return (op == OP_MUL);
    endfunction

endpackage

// File: rtl/calc_rf.sv
// Register file: one synchronous write port, two combinational read ports, cleared by reset.
module calc_rf #(
    parameter int  WIDTH = 3,
    parameter int  NREGS = 4,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] r_mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata_a = r_mem[raddr_a];
    assign rdata_b = r_mem[raddr_b];

endmodule

// File: rtl/calc_datapath_p.sv
// Single-issue calculator over a small register file; one-cycle ALU ops and an
// iterative shift-add multiplier that retires one multiplier bit per cycle.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | ready for a command; cmd_ready high
//   ST_EXEC | single-cycle op captured; result written on the next edge
//   ST_MUL  | shift-add multiply in progress; r_cnt bits still to retire
module calc_datapath_p
    import calc_pkg::*;
#(
    parameter int  WIDTH = 3,
    parameter int  NREGS = 4,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [AW-1:0]    cmd_dst,
    input  logic [AW-1:0]    cmd_srca,
    input  logic [AW-1:0]    cmd_srcb,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e             r_state;
    state_e             w_state_nxt;

    op_e                r_op;
    logic [AW-1:0]      r_dst;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_in1;
    logic [WIDTH-1:0]   r_in2;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [CW-1:0]      r_cnt;

    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_out_ovf;

    logic               w_accept;
    logic               w_mul_last;
    logic               w_we;
    logic [WIDTH-1:0]   w_rd_a;
    logic [WIDTH-1:0]   w_rd_b;
    logic [WIDTH-1:0]   w_res;
    logic               w_ovf;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_mul_step;

    assign cmd_ready  = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_mul_last = (r_state == ST_MUL) && (r_cnt == CW'(1));
    assign w_we       = (r_state == ST_EXEC) || w_mul_last;

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_ovf    = r_out_ovf;

    calc_rf #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (w_we),
        .waddr   (r_dst),
        .wdata   (w_res),
        .raddr_a (cmd_srca),
        .rdata_a (w_rd_a),
        .raddr_b (cmd_srcb),
        .rdata_b (w_rd_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = is_multicycle(op_e'(cmd_op)) ? ST_MUL : ST_EXEC;
                end
            end
            ST_EXEC: w_state_nxt = ST_IDLE;
            ST_MUL: begin
                if (w_mul_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Extra top bit of sum/difference is the carry-out and the borrow respectively.
    assign w_sum      = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff     = {1'b0, r_a} - {1'b0, r_b};
    assign w_mul_step = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (r_op)
            OP_LOAD1: w_res = r_in1;
            OP_LOAD2: w_res = r_in2;
            OP_CLR:   w_res = '0;
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_ovf = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_ovf = w_diff[WIDTH];
            end
            OP_AND:   w_res = r_a & r_b;
            OP_XOR:   w_res = r_a ^ r_b;
            OP_MUL: begin
                w_res = w_mul_step[WIDTH-1:0];
                w_ovf = |w_mul_step[2*WIDTH-1:WIDTH];
            end
            default: begin
                w_res = '0;
                w_ovf = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op        <= OP_LOAD1;
            r_dst       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_in1       <= '0;
            r_in2       <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            r_out_valid <= w_we;
            if (w_we) begin
                r_out_data <= w_res;
                r_out_ovf  <= w_ovf;
            end
            if (w_accept) begin
                r_op     <= op_e'(cmd_op);
                r_dst    <= cmd_dst;
                r_a      <= w_rd_a;
                r_b      <= w_rd_b;
                r_in1    <= in1;
                r_in2    <= in2;
                r_acc    <= '0;
                r_mcand  <= {{WIDTH{1'b0}}, w_rd_a};
                r_mplier <= w_rd_b;
                r_cnt    <= CW'(WIDTH);
            end else if (r_state == ST_MUL) begin
                // Last step is folded into w_mul_step and written straight to the rf.
                r_acc    <= w_mul_step;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_calc_datapath_p.sv
// Directed + randomized bench for calc_datapath_p at WIDTH=3/NREGS=4, plus a WIDTH=8/NREGS=8 instance.
module tb_calc_datapath_p;

    localparam int W = 3;
    localparam int M = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] in1, in2;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [1:0] cmd_dst, cmd_srca, cmd_srcb;
    logic       out_valid;
    logic [2:0] out_data;
    logic       out_ovf;
    logic       busy;

    logic [7:0] c8_in1, c8_in2;
    logic       c8_valid;
    logic       o8_ready;
    logic [2:0] c8_op;
    logic [2:0] c8_dst, c8_sa, c8_sb;
    logic       o8_valid;
    logic [7:0] o8_data;
    logic       o8_ovf;
    logic       o8_busy;

    calc_datapath_p #(.WIDTH(3), .NREGS(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in1       (in1),
        .in2       (in2),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_dst   (cmd_dst),
        .cmd_srca  (cmd_srca),
        .cmd_srcb  (cmd_srcb),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    calc_datapath_p #(.WIDTH(8), .NREGS(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in1       (c8_in1),
        .in2       (c8_in2),
        .cmd_valid (c8_valid),
        .cmd_ready (o8_ready),
        .cmd_op    (c8_op),
        .cmd_dst   (c8_dst),
        .cmd_srca  (c8_sa),
        .cmd_srcb  (c8_sb),
        .out_valid (o8_valid),
        .out_data  (o8_data),
        .out_ovf   (o8_ovf),
        .busy      (o8_busy)
    );

    int nvec  = 0;
    int nfail = 0;
    int mrf[4];
    int last_d, last_o;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference semantics straight from the op table, modulo m.
    function automatic void ref_op(input int op, input int a, input int b, input int i1,
                                   input int i2, input int m, output int d, output int o);
        o = 0;
        case (op)
            0: d = i1;
            1: d = i2;
            2: d = 0;
            3: begin d = (a + b) % m; o = int'(a + b >= m); end
            4: begin d = (a - b + m) % m; o = int'(a < b); end
            5: d = a & b;
            6: d = a ^ b;
            default: begin d = (a * b) % m; o = int'(a * b >= m); end
        endcase
    endfunction

    task automatic do_cmd(input int op, input int dst, input int sa, input int sb,
                          input int i1, input int i2);
        int ed, eo, n, bc, k, lat;
        ref_op(op, mrf[sa], mrf[sb], i1, i2, M, ed, eo);
        lat = (op == 7) ? W : 1;
        k = 0;
        while (!cmd_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = 3'(op);
        cmd_dst   = 2'(dst);
        cmd_srca  = 2'(sa);
        cmd_srcb  = 2'(sb);
        in1       = 3'(i1);
        in2       = 3'(i2);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_dst   = 2'($urandom);
        cmd_srca  = 2'($urandom);
        cmd_srcb  = 2'($urandom);
        in1       = 3'($urandom);
        in2       = 3'($urandom);
        n  = 0;
        bc = 0;
        while (!out_valid && n < 20) begin
            if (busy) bc++;
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, lat);
        chk("busy_cycles", bc, lat);
        chk("out_data", out_data, ed);
        chk("out_ovf", out_ovf, eo);
        mrf[dst] = ed;
        last_d   = ed;
        last_o   = eo;
    endtask

    task automatic cmd8(input int op, input int dst, input int sa, input int sb, input int i1,
                        input int i2, input int ed, input int eo, input int lat);
        int n;
        c8_valid = 1'b1;
        c8_op    = 3'(op);
        c8_dst   = 3'(dst);
        c8_sa    = 3'(sa);
        c8_sb    = 3'(sb);
        c8_in1   = 8'(i1);
        c8_in2   = 8'(i2);
        @(posedge clk); #1;
        c8_valid = 1'b0;
        n = 0;
        while (!o8_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("w8_latency", n, lat);
        chk("w8_data", o8_data, ed);
        chk("w8_ovf", o8_ovf, eo);
    endtask

    initial begin
        int e1d, e1o, e2d, e2o, n, gap;
        cmd_valid = 1'b0; cmd_op = '0; cmd_dst = '0; cmd_srca = '0; cmd_srcb = '0;
        in1 = '0; in2 = '0;
        c8_valid = 1'b0; c8_op = '0; c8_dst = '0; c8_sa = '0; c8_sb = '0;
        c8_in1 = '0; c8_in2 = '0;
        for (int i = 0; i < 4; i++) mrf[i] = 0;

        // Reset with a command pending: nothing may be accepted.
        repeat (2) @(posedge clk);
        #1;
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_dst = 2'd1; in1 = 3'd7;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ovf", out_ovf, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_w8_data", o8_data, 0);
        chk("rst_w8_ready", o8_ready, 1);
        cmd_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;

        // First command accepted at the first edge after release.
        do_cmd(0, 2, 0, 0, 5, 0);
        chk("load1_5", out_data, 5);
        @(posedge clk); #1;
        chk("strobe_single", out_valid, 0);
        chk("data_hold", out_data, 5);
        do_cmd(3, 3, 2, 2, 0, 0);
        chk("add_wrap", out_data, 2);
        chk("add_carry", out_ovf, 1);
        do_cmd(5, 3, 3, 3, 0, 0);
        chk("rf3_peek", out_data, 2);

        do_cmd(0, 0, 0, 0, 3, 0);
        do_cmd(1, 1, 0, 0, 0, 5);
        do_cmd(4, 2, 0, 1, 0, 0);
        chk("sub_3_5", out_data, 6);
        chk("sub_borrow", out_ovf, 1);
        do_cmd(5, 2, 0, 1, 0, 0);
        chk("and_3_5", out_data, 1);
        do_cmd(6, 2, 0, 1, 0, 0);
        chk("xor_3_5", out_data, 6);
        chk("xor_ovf", out_ovf, 0);

        do_cmd(7, 2, 0, 0, 0, 0);
        chk("mul_3_3", out_data, 1);
        chk("mul_3_3_ovf", out_ovf, 1);
        do_cmd(0, 1, 0, 0, 2, 0);
        do_cmd(7, 3, 1, 0, 0, 0);
        chk("mul_2_3", out_data, 6);
        chk("mul_2_3_ovf", out_ovf, 0);
        do_cmd(3, 0, 0, 0, 0, 0);

        // cmd_valid held high across a MUL; next command taken in the strobe cycle.
        ref_op(7, mrf[3], mrf[3], 0, 0, M, e1d, e1o);
        cmd_valid = 1'b1; cmd_op = 3'd7; cmd_dst = 2'd2; cmd_srca = 2'd3; cmd_srcb = 2'd3;
        @(posedge clk); #1;
        cmd_op = 3'd3; cmd_dst = 2'd1; cmd_srca = 2'd2; cmd_srcb = 2'd0;
        n = 0;
        while (!out_valid && n < 20) begin
            chk("b2b_ready_low", cmd_ready, 0);
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_mul_lat", n, W);
        chk("b2b_mul_data", out_data, e1d);
        chk("b2b_mul_ovf", out_ovf, e1o);
        chk("b2b_ready_in_strobe", cmd_ready, 1);
        mrf[2] = e1d;
        ref_op(3, mrf[2], mrf[0], 0, 0, M, e2d, e2o);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("b2b_gap", out_valid, 0);
        chk("b2b_second_busy", busy, 1);
        @(posedge clk); #1;
        chk("b2b_add_valid", out_valid, 1);
        chk("b2b_add_data", out_data, e2d);
        chk("b2b_add_ovf", out_ovf, e2o);
        mrf[1] = e2d;
        @(posedge clk); #1;
        chk("b2b_no_extra", out_valid, 0);

        for (int i = 0; i < 80; i++) begin
            do_cmd($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7));
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                @(posedge clk); #1;
                chk("rand_strobe_single", out_valid, 0);
                chk("rand_hold_data", out_data, last_d);
                chk("rand_hold_ovf", out_ovf, last_o);
                repeat (gap - 1) @(posedge clk);
                #1;
            end
        end

        // Reset during MUL cycle 2 aborts the multiply and clears the rf.
        do_cmd(0, 1, 0, 0, 3, 0);
        do_cmd(0, 2, 0, 0, 3, 0);
        cmd_valid = 1'b1; cmd_op = 3'd7; cmd_dst = 2'd0; cmd_srca = 2'd1; cmd_srcb = 2'd2;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("mul_busy_before_rst", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", cmd_ready, 1);
        chk("abort_data", out_data, 0);
        chk("abort_ovf", out_ovf, 0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) mrf[i] = 0;
        for (int k = 0; k < W + 2; k++) begin
            @(posedge clk); #1;
            chk("abort_no_strobe", out_valid, 0);
        end
        for (int r = 0; r < 4; r++) begin
            do_cmd(5, r, r, r, 0, 0);
            chk("abort_rf_zero", out_data, 0);
        end

        // 8-bit instance.
        cmd8(0, 0, 0, 0, 200, 0, 200, 0, 1);
        cmd8(1, 1, 0, 0, 0, 100, 100, 0, 1);
        cmd8(3, 2, 0, 1, 0, 0, 44, 1, 1);
        cmd8(7, 3, 0, 1, 0, 0, 32, 1, 8);
        cmd8(2, 2, 0, 0, 0, 0, 0, 0, 1);
        cmd8(5, 2, 2, 2, 0, 0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
